board_sprite_renderer: RTL



---
 rtl/board_sprite_renderer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/board_sprite_renderer.sv
// board_sprite_renderer: scans a flat board vector against a shadow copy and,
// for each changed cell, streams a SPRITE_W x SPRITE_H sprite (selected by the
// cell value) from an external 1-cycle-latency ROM into the vga_adapter.
// Optional feature macro: BOARD_SPRITE_TRANSPARENT_EN. When it is defined,
// pixels whose colour equals TRANSPARENT_COLOUR are not plotted.
module board_sprite_renderer #(
  parameter int ROWS     = 6,
  parameter int COLS     = 7,
  parameter int CELL_W   = 2,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int X0       = 37,
  parameter int Y0       = 24,
  parameter int PITCH_X  = 13,
  parameter int PITCH_Y  = 13,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
`ifdef BOARD_SPRITE_TRANSPARENT_EN
  ,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = '0
`endif
) (
  input  logic                                   CLOCK_50,
  input  logic                                   Resetn,
  input  logic [ROWS*COLS*CELL_W-1:0]            board,
  output logic [CELL_W-1:0]                      sprite_sel,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]   sprite_addr,
  input  logic [COLOUR_W-1:0]                    sprite_q,
  output logic [X_W-1:0]                         vga_x,
  output logic [Y_W-1:0]                         vga_y,
  output logic [COLOUR_W-1:0]                    vga_colour,
  output logic                                   vga_plot,
  output logic                                   busy,
  output logic [15:0]                            draw_count
);

  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int XC_W  = $clog2(SPRITE_W);
  localparam int YC_W  = $clog2(SPRITE_H);

  typedef enum logic [1:0] {S_SCAN, S_DRAW, S_DRAIN} state_t;

  state_t                    r_state;
  logic [NCELL*CELL_W-1:0]   r_board;
  logic [NCELL*CELL_W-1:0]   r_shadow;
  logic [IDX_W-1:0]          r_idx;
  logic [ROW_W-1:0]          r_row;
  logic [COL_W-1:0]          r_col;
  logic [CELL_W-1:0]         r_sel;
  logic [X_W-1:0]            r_ox;
  logic [Y_W-1:0]            r_oy;
  logic [XC_W-1:0]           r_xc;
  logic [YC_W-1:0]           r_yc;
  logic [X_W-1:0]            r_vx;
  logic [Y_W-1:0]            r_vy;
  logic                      r_plot;
  logic                      r_busy;
  logic [15:0]               r_count;

  logic [CELL_W-1:0]         w_cur;
  logic [CELL_W-1:0]         w_shd;
  logic [X_W-1:0]            w_ox;
  logic [Y_W-1:0]            w_oy;
  logic [IDX_W-1:0]          w_idx_nx;
  logic [ROW_W-1:0]          w_row_nx;
  logic [COL_W-1:0]          w_col_nx;

  assign w_cur = r_board[int'(r_idx)*CELL_W +: CELL_W];
  assign w_shd = r_shadow[int'(r_idx)*CELL_W +: CELL_W];
  // Row/column are tracked alongside idx so the origin needs only constant multiplies.
  assign w_ox  = X_W'(X0 + PITCH_X * int'(r_col));
  assign w_oy  = Y_W'(Y0 + PITCH_Y * int'(r_row));

  // Board input is registered once; the scan always compares against this copy.
  always_ff @(posedge CLOCK_50) begin
    r_board <= board;
  end

  // Next scan position: advance column, carry into row, wrap after the last cell.
  always_comb begin
    w_idx_nx = r_idx + 1'b1;
    w_row_nx = r_row;
    w_col_nx = r_col + 1'b1;
    if (r_col == COL_W'(COLS - 1)) begin
      w_col_nx = '0;
      w_row_nx = r_row + 1'b1;
    end
    if (r_idx == IDX_W'(NCELL - 1)) begin
      w_idx_nx = '0;
      w_row_nx = '0;
      w_col_nx = '0;
    end
  end

  // Scan/draw/drain sequencer with the one-cycle pixel pipeline aligned to sprite_q.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_SCAN;
      r_shadow <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_sel    <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_xc     <= '0;
      r_yc     <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_plot <= (r_state == S_DRAW);
      if (r_state == S_DRAW) begin
        r_vx <= r_ox + X_W'(r_xc);
        r_vy <= r_oy + Y_W'(r_yc);
      end
      case (r_state)
        S_SCAN: begin
          if (w_cur != w_shd) begin
            r_sel   <= w_cur;
            r_ox    <= w_ox;
            r_oy    <= w_oy;
            r_xc    <= '0;
            r_yc    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_DRAW;
          end else begin
            r_idx <= w_idx_nx;
            r_row <= w_row_nx;
            r_col <= w_col_nx;
          end
        end
        S_DRAW: begin
          r_xc <= r_xc + 1'b1;
          if (r_xc == XC_W'(SPRITE_W - 1)) begin
            r_yc <= r_yc + 1'b1;
            if (r_yc == YC_W'(SPRITE_H - 1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Record the value actually drawn so a newer board value is picked up later.
          r_shadow[int'(r_idx)*CELL_W +: CELL_W] <= r_sel;
          r_count <= r_count + 16'd1;
          r_idx   <= w_idx_nx;
          r_row   <= w_row_nx;
          r_col   <= w_col_nx;
          r_busy  <= 1'b0;
          r_state <= S_SCAN;
        end
        default: begin
          r_state <= S_SCAN;
        end
      endcase
    end
  end

  assign sprite_sel  = r_sel;
  assign sprite_addr = {r_yc, r_xc};
  assign vga_x       = r_vx;
  assign vga_y       = r_vy;
  assign vga_colour  = sprite_q;
  assign busy        = r_busy;
  assign draw_count  = r_count;

`ifdef BOARD_SPRITE_TRANSPARENT_EN
  assign vga_plot = r_plot & (sprite_q != TRANSPARENT_COLOUR);
`else
  assign vga_plot = r_plot;
`endif

endmodule
